// File: rtl/param_memory_pkg.sv
// Shared definitions for param_memory: error codes and init/run state encoding.
package param_memory_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_WADDR = 2'd1,
    ERR_RADDR = 2'd2,
    ERR_BUSY  = 2'd3
  } err_code_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/param_memory_mem_init_ctrl.sv
// Init sequencer: after reset walks every entry once, then hands the array to the user ports.
module mem_init_ctrl
  import param_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == ST_INIT) begin
      // The last entry is written in the same cycle the FSM leaves INIT.
      if (cnt_q == LAST_ADDR) begin
        state_q <= ST_RUN;
        busy_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + ADDR_WIDTH'(1);
      end
    end else begin
      state_q <= ST_RUN;
      busy_q  <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign init_we   = busy_q;
  assign init_addr = cnt_q;

endmodule

// File: rtl/param_memory.sv
// Single write / registered read memory with self-clearing init, selectable
// read-during-write and a sticky first-error code.
module param_memory
  import param_memory_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 16,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  activate,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  error,
  output logic [1:0]            err_code,
  input  logic                  error_clr
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q;
  logic                  error_q;
  err_code_e             err_code_q;
  err_code_e             err_new;

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  waddr_ok, raddr_ok;
  logic                  wr_req, rd_req, wr_fire, rd_fire;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  mem_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_init (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign waddr_ok = {1'b0, waddr} < DEPTH_W;
  assign raddr_ok = {1'b0, raddr} < DEPTH_W;
  assign wr_req   = activate & write;
  assign rd_req   = activate & read;
  assign wr_fire  = ~busy & wr_req & waddr_ok;
  assign rd_fire  = ~busy & rd_req & raddr_ok;

  // The init sequencer owns the write port for the whole of INIT.
  assign mem_we    = busy ? init_we    : wr_fire;
  assign mem_addr  = busy ? init_addr  : waddr;
  assign mem_wdata = busy ? INIT_VALUE : wdata;

  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    rdata_d = mem_q[raddr];
    if (RDW_MODE == 1 && wr_fire && (waddr == raddr)) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) begin
        rdata_q <= rdata_d;
      end
    end
  end

  always_comb begin
    err_new = ERR_NONE;
    if (busy && (wr_req || rd_req)) begin
      err_new = ERR_BUSY;
    end else if (wr_req && !waddr_ok) begin
      err_new = ERR_WADDR;
    end else if (rd_req && !raddr_ok) begin
      err_new = ERR_RADDR;
    end
  end

  // A new error beats a simultaneous clear; otherwise the first code is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if ((err_new != ERR_NONE) && (!error_q || error_clr)) begin
      error_q    <= 1'b1;
      err_code_q <= err_new;
    end else if (error_clr) begin
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: three configurations share one stimulus stream,
// each followed by a reference model feeding a read-data scoreboard.
module tb_param_memory;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       activate = 1'b0;
  logic       write = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       read = 1'b0;
  logic [3:0] raddr = '0;
  logic       error_clr = 1'b0;

  logic [7:0] rdata    [3];
  logic       rvalid   [3];
  logic       busy     [3];
  logic       error    [3];
  logic [1:0] err_code [3];

  always #5 clk = ~clk;

  param_memory u_a (
    .clk(clk), .reset(reset), .activate(activate), .write(write), .waddr(waddr),
    .wdata(wdata), .read(read), .raddr(raddr), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .busy(busy[0]), .error(error[0]), .err_code(err_code[0]), .error_clr(error_clr)
  );

  param_memory #(.RDW_MODE(1), .INIT_VALUE(8'h5A)) u_b (
    .clk(clk), .reset(reset), .activate(activate), .write(write), .waddr(waddr),
    .wdata(wdata), .read(read), .raddr(raddr), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .busy(busy[1]), .error(error[1]), .err_code(err_code[1]), .error_clr(error_clr)
  );

  param_memory #(.DEPTH(12)) u_c (
    .clk(clk), .reset(reset), .activate(activate), .write(write), .waddr(waddr),
    .wdata(wdata), .read(read), .raddr(raddr), .rdata(rdata[2]), .rvalid(rvalid[2]),
    .busy(busy[2]), .error(error[2]), .err_code(err_code[2]), .error_clr(error_clr)
  );

  localparam int         DEP   [3] = '{16, 16, 12};
  localparam int         RDW   [3] = '{0, 1, 0};
  localparam logic [7:0] INITV [3] = '{8'h00, 8'h5A, 8'h00};

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] m_mem  [3][16];
  logic       m_busy [3];
  int         m_cnt  [3];
  logic [7:0] m_rd   [3];
  logic       m_err  [3];
  int         m_code [3];
  logic       m_rv   [3];

  int n_vec  = 0;
  int n_miss = 0;
  int n_cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, n_cyc, got, expv);
    end
  endtask

  // Advance the reference model by one edge, then compare every instance.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      int         nerr;
      logic       wok, rok;
      logic [7:0] rv;
      nerr    = 0;
      m_rv[i] = 1'b0;
      if (reset) begin
        m_busy[i] = 1'b1;
        m_cnt[i]  = 0;
        m_rd[i]   = 8'h00;
        m_err[i]  = 1'b0;
        m_code[i] = 0;
      end else begin
        if (m_busy[i]) begin
          if (activate && (read || write)) nerr = 3;
          m_mem[i][m_cnt[i]] = INITV[i];
          m_cnt[i]++;
          if (m_cnt[i] == DEP[i]) m_busy[i] = 1'b0;
        end else begin
          wok = int'(waddr) < DEP[i];
          rok = int'(raddr) < DEP[i];
          if (activate && write && !wok) nerr = 1;
          else if (activate && read && !rok) nerr = 2;
          if (activate && read && rok) begin
            if (RDW[i] == 1 && write && wok && waddr == raddr) rv = wdata;
            else rv = m_mem[i][raddr];
            exp_q.push_back('{inst: 2'(i), data: rv});
            m_rv[i] = 1'b1;
            m_rd[i] = rv;
          end
          if (activate && write && wok) m_mem[i][waddr] = wdata;
        end
        if (nerr != 0 && (!m_err[i] || error_clr)) begin
          m_err[i]  = 1'b1;
          m_code[i] = nerr;
        end else if (error_clr) begin
          m_err[i]  = 1'b0;
          m_code[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    n_cyc++;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
      chk($sformatf("error%0d", i), 32'(error[i]), 32'(m_err[i]));
      chk($sformatf("err_code%0d", i), 32'(err_code[i]), 32'(m_code[i]));
      chk($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(m_rv[i]));
      if (rvalid[i]) begin
        if (exp_q.size() > 0 && exp_q[0].inst == 2'(i)) begin
          e = exp_q.pop_front();
          chk($sformatf("rdata%0d", i), 32'(rdata[i]), 32'(e.data));
        end else begin
          chk($sformatf("sb_unexpected%0d", i), 32'(1), 32'(0));
        end
      end else begin
        chk($sformatf("rdata_hold%0d", i), 32'(rdata[i]), 32'(m_rd[i]));
      end
    end
    chk("sb_leftover", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    $display("cyc %0d rst=%0b act=%0b wr=%0b wa=%0h wd=%0h rd=%0b ra=%0h clr=%0b | rd=%0h/%0h/%0h rv=%0b%0b%0b busy=%0b%0b%0b err=%0d/%0d/%0d",
             n_cyc, reset, activate, write, waddr, wdata, read, raddr, error_clr,
             rdata[0], rdata[1], rdata[2], rvalid[0], rvalid[1], rvalid[2],
             busy[0], busy[1], busy[2], err_code[0], err_code[1], err_code[2]);
  endtask

  task automatic drive(input logic act, input logic wr, input logic [3:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [3:0] ra, input logic clr);
    activate  = act;
    write     = wr;
    waddr     = wa;
    wdata     = wd;
    read      = rd;
    raddr     = ra;
    error_clr = clr;
    step();
  endtask

  // Counts busy samples from the reset edge onward, optionally injecting a write at init cycle 4.
  task automatic run_init(input logic poke, output int nb);
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy[0]) break;
      nb++;
      activate = poke && (k == 3);
      write    = poke && (k == 3);
      waddr    = 4'h2;
      wdata    = 8'hEE;
      step();
    end
    activate = 1'b0;
    write    = 1'b0;
  endtask

  initial begin
    int nb;
    for (int i = 0; i < 3; i++) m_busy[i] = 1'b1;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("reset_rdata", 32'(rdata[0]), 32'h00);
    chk("reset_busy", 32'(busy[0]), 32'd1);
    reset = 1'b0;

    run_init(1'b1, nb);
    chk("busy_cycles", 32'(nb), 32'd16);
    chk("busy_req_code", 32'(err_code[0]), 32'd3);
    drive(0, 0, 0, 0, 0, 0, 1);

    for (int a = 0; a < 16; a++) drive(1, 0, 0, 0, 1, 4'(a), 0);
    drive(0, 0, 0, 0, 0, 0, 1);

    drive(1, 1, 4'd3, 8'hA5, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 4'd3, 0);
    chk("a5_read", 32'(rdata[0]), 32'hA5);
    chk("a5_rvalid", 32'(rvalid[0]), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a5_idle_rvalid", 32'(rvalid[0]), 32'd0);
    chk("a5_idle_hold", 32'(rdata[0]), 32'hA5);

    drive(1, 1, 4'd5, 8'h11, 0, 0, 0);
    drive(1, 1, 4'd5, 8'h22, 1, 4'd5, 0);
    chk("rdw_old", 32'(rdata[0]), 32'h11);
    chk("rdw_through", 32'(rdata[1]), 32'h22);
    drive(1, 0, 0, 0, 1, 4'd5, 0);
    chk("rdw_after0", 32'(rdata[0]), 32'h22);
    chk("rdw_after1", 32'(rdata[1]), 32'h22);

    drive(1, 1, 4'd13, 8'h37, 0, 0, 0);
    chk("oor_w_code", 32'(err_code[2]), 32'd1);
    drive(1, 0, 0, 0, 1, 4'd14, 0);
    chk("oor_r_keep", 32'(err_code[2]), 32'd1);
    chk("oor_r_rvalid", 32'(rvalid[2]), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("clr_error", 32'(error[2]), 32'd0);
    drive(1, 0, 0, 0, 1, 4'd13, 0);
    chk("oor_r_code", 32'(err_code[2]), 32'd2);
    drive(1, 1, 4'd15, 8'h44, 1, 4'd15, 1);
    chk("clr_vs_new", 32'(err_code[2]), 32'd1);
    drive(0, 1, 4'd14, 8'h55, 1, 4'd14, 1);
    drive(0, 1, 4'd13, 8'h66, 1, 4'd12, 0);
    chk("inactive_err", 32'(error[2]), 32'd0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) drive(1, 1, 4'(k), 8'h99, 0, 0, 1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    run_init(1'b0, nb);
    chk("rerun_busy_cycles", 32'(nb), 32'd16);
    for (int a = 0; a < 16; a++) drive(1, 0, 0, 0, 1, 4'(a), a == 15);

    for (int k = 0; k < 200; k++) begin
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom), 4'($urandom), 8'($urandom),
            1'($urandom), 4'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
